// File: rtl/mpsoc_ahb4_spram_ws.sv
// AHB4-Lite single-port RAM slave with configurable data-phase wait states,
// byte-lane writes from HSIZE/HADDR and two-cycle ERROR responses.
module mpsoc_ahb4_spram_ws #(
  parameter int              XLEN        = 64,
  parameter int              PLEN        = 64,
  parameter int              MEM_DEPTH   = 256,
  parameter logic [PLEN-1:0] BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int              BYTES     = XLEN / 8;
  localparam int              LANE_W    = $clog2(BYTES);
  localparam int              IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [PLEN-1:0] MEM_BYTES = PLEN'(MEM_DEPTH * BYTES);
  localparam logic [2:0]      MAX_SIZE  = 3'(LANE_W);
  localparam logic [2:0]      WS_LOAD   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               dp_valid_q;
  logic               write_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BYTES-1:0]   be_q;
  logic [XLEN-1:0]    mem_q [MEM_DEPTH];

  logic               accept_s;
  logic               err_s;
  logic               ready_s;
  logic               resp_s;
  logic               commit_s;
  logic [PLEN-1:0]    offset_s;
  logic [IDX_W-1:0]   idx_s;
  logic [LANE_W-1:0]  lane_s;
  logic [7:0]         nbytes_s;
  logic [6:0]         align_mask_s;
  logic [BYTES-1:0]   be_s;
  logic               unused_s;

  assign unused_s = ^{HBURST, HPROT, HMASTLOCK};

  assign accept_s     = HSEL & HREADY & HTRANS[1];
  assign offset_s     = HADDR - BASE_ADDR;
  assign idx_s        = offset_s[LANE_W +: IDX_W];
  assign lane_s       = HADDR[LANE_W-1:0];
  assign nbytes_s     = 8'd1 << HSIZE;
  assign align_mask_s = (7'd1 << HSIZE) - 7'd1;

  assign err_s = (HADDR < BASE_ADDR)
               | (offset_s >= MEM_BYTES)
               | (HSIZE > MAX_SIZE)
               | ((HADDR[6:0] & align_mask_s) != 7'd0);

  // Lane mask: nbytes_s consecutive lanes starting at the address lane.
  always_comb begin
    be_s = '0;
    for (int i = 0; i < BYTES; i++) begin
      if ((i >= int'(lane_s)) && (i < int'(lane_s) + int'(nbytes_s))) begin
        be_s[i] = 1'b1;
      end else begin
        be_s[i] = 1'b0;
      end
    end
  end

  // Next-state, wait counter and response decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_s = 1'b1;
    resp_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        resp_s = (state_q == ST_ERR2);
        if (accept_s) begin
          if (err_s) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        ready_s = 1'b0;
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        ready_s = 1'b0;
        resp_s  = 1'b1;
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data-phase context: only advances while this slave is ready, so a
  // reset mid-transfer drops the pending access entirely.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      be_q       <= '0;
    end else if (ready_s) begin
      dp_valid_q <= accept_s & ~err_s;
      if (accept_s) begin
        write_q <= HWRITE;
        idx_q   <= idx_s;
        be_q    <= be_s;
      end else begin
        write_q <= write_q;
      end
    end else begin
      dp_valid_q <= dp_valid_q;
    end
  end

  assign commit_s = (state_q == ST_IDLE) & dp_valid_q & write_q;

  // Byte-lane memory write at the end of an OKAY write data phase.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < BYTES; i++) begin
      if (commit_s && be_q[i]) begin
        mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = ready_s;
  assign HRESP     = resp_s;
  assign HRDATA    = ((state_q == ST_IDLE) && dp_valid_q && !write_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_mpsoc_ahb4_spram_ws.sv
// Bench for mpsoc_ahb4_spram_ws: three instances (0, 2, 3 wait states) on a
// shared bus, checked every cycle against a transaction-level response model.
module tb_mpsoc_ahb4_spram_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, hmastlock;
  logic [63:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  int          dsel;

  logic        rdy0, rdy1, rdy2, rsp0, rsp1, rsp2;
  logic [63:0] rd0, rd1, rd2;
  logic        hready_bus, hresp_bus;
  logic [63:0] hrdata_bus;

  int compared = 0;
  int failed   = 0;
  int low_cnt  = 0;
  int resp_cnt = 0;
  logic [63:0] last_rd;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic        done_rd;
    logic        done_wr;
    int          dut;
    int          idx;
    logic [7:0]  be;
    logic [63:0] wd;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] mem_m [3][256];

  always #5 clk = ~clk;

  always_comb begin
    case (dsel)
      0:       begin hready_bus = rdy0; hresp_bus = rsp0; hrdata_bus = rd0; end
      1:       begin hready_bus = rdy1; hresp_bus = rsp1; hrdata_bus = rd1; end
      default: begin hready_bus = rdy2; hresp_bus = rsp2; hrdata_bus = rd2; end
    endcase
  end

  mpsoc_ahb4_spram_ws #(.WAIT_STATES(0)) u_w0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel && dsel == 0), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready_bus), .HREADYOUT(rdy0), .HRESP(rsp0));
  mpsoc_ahb4_spram_ws #(.WAIT_STATES(2)) u_w2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel && dsel == 1), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready_bus), .HREADYOUT(rdy1), .HRESP(rsp1));
  mpsoc_ahb4_spram_ws #(.WAIT_STATES(3)) u_w3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel && dsel == 2), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rd2), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready_bus), .HREADYOUT(rdy2), .HRESP(rsp2));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  // Expected response sequence for one accepted transfer.
  function automatic void push_model(input logic wr, input logic [63:0] a,
                                     input logic [2:0] sz, input logic [63:0] wd);
    exp_t e;
    int   nb;
    int   lane;
    logic err;
    nb   = 1 << sz;
    lane = int'(a % 64'd8);
    err  = (a >= 64'd2048) || (sz > 3'd3) || ((a % 64'(nb)) != 64'd0);
    e = '{rdy: 1'b0, resp: 1'b0, done_rd: 1'b0, done_wr: 1'b0, dut: dsel, idx: 0, be: 8'd0, wd: 64'd0};
    if (err) begin
      e.resp = 1'b1;
      expq.push_back(e);
      e.rdy = 1'b1;
      expq.push_back(e);
    end else begin
      for (int k = 0; k < ws_of(dsel); k++) expq.push_back(e);
      e.rdy     = 1'b1;
      e.idx     = int'(a / 64'd8);
      e.done_rd = !wr;
      e.done_wr = wr;
      e.be      = 8'(((1 << nb) - 1) << lane);
      e.wd      = wd;
      expq.push_back(e);
    end
  endfunction

  task automatic check_lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    exp_t        e;
    logic [63:0] er;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) e = expq.pop_front();
      else e = '{rdy: 1'b1, resp: 1'b0, done_rd: 1'b0, done_wr: 1'b0, dut: 0, idx: 0, be: 8'd0, wd: 64'd0};
      er = 64'd0;
      if (e.done_rd) er = mem_m[e.dut][e.idx];
      if (e.done_wr) begin
        for (int i = 0; i < 8; i++) begin
          if (e.be[i]) mem_m[e.dut][e.idx][8*i +: 8] = e.wd[8*i +: 8];
        end
      end
      compared += 3;
      if (hready_bus !== e.rdy) begin
        failed++;
        $display("FAIL hreadyout @%0t: got %b, expected %b", $time, hready_bus, e.rdy);
      end
      if (hresp_bus !== e.resp) begin
        failed++;
        $display("FAIL hresp @%0t: got %b, expected %b", $time, hresp_bus, e.resp);
      end
      if (hrdata_bus !== er) begin
        failed++;
        $display("FAIL hrdata @%0t: got %h, expected %h", $time, hrdata_bus, er);
      end
      if (hready_bus !== 1'b1) low_cnt++;
      if (hresp_bus === 1'b1) resp_cnt++;
      if (e.done_rd) last_rd = hrdata_bus;
    end
  end

  // Present one address phase, wait for HREADY, then drive its data phase.
  task automatic issue(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [63:0] a, input logic [2:0] sz, input logic [63:0] wd);
    int guard;
    guard  = 0;
    hsel   = sel;
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
    @(negedge clk);
    while (hready_bus !== 1'b1 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) begin
      compared++;
      failed++;
      $display("FAIL hready_timeout: got low for %0d cycles, expected high within 50", guard);
    end
    @(posedge clk);
    #1;
    hwdata = wd;
    if (sel && tr[1]) push_model(wr, a, sz, wd);
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic idle(input int n);
    hsel   = 1'b0;
    htrans = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic zero_words();
    issue(1'b1, 2'b10, 1'b1, 64'h10, 3'd3, 64'd0);
    issue(1'b1, 2'b10, 1'b1, 64'h20, 3'd3, 64'd0);
    issue(1'b1, 2'b10, 1'b1, 64'h7F8, 3'd3, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) for (int w = 0; w < 256; w++) mem_m[d][w] = 64'd0;
    rst = 1'b1; hsel = 1'b0; hwrite = 1'b0; hmastlock = 1'b0; haddr = 64'd0;
    hwdata = 64'd0; hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; htrans = 2'b00;
    dsel = 0; last_rd = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_lit("reset_hreadyout", {63'd0, hready_bus}, 64'd1);
    check_lit("reset_hresp", {63'd0, hresp_bus}, 64'd0);
    rst = 1'b0;

    // Zero wait states: full write, then immediate read of the same word.
    dsel = 0;
    zero_words();
    issue(1'b1, 2'b10, 1'b1, 64'h10, 3'd3, 64'h1122334455667788);
    issue(1'b1, 2'b10, 1'b0, 64'h10, 3'd3, 64'd0);
    idle(2);
    check_lit("rd_full_word", last_rd, 64'h1122334455667788);
    issue(1'b1, 2'b10, 1'b1, 64'h13, 3'd0, 64'h55555555AB555555);
    issue(1'b1, 2'b11, 1'b0, 64'h10, 3'd3, 64'd0);
    idle(2);
    check_lit("rd_after_byte", last_rd, 64'h11223344AB667788);
    issue(1'b1, 2'b10, 1'b1, 64'h16, 3'd1, 64'hBEEF123456789ABC);
    issue(1'b1, 2'b10, 1'b0, 64'h10, 3'd3, 64'd0);
    idle(2);
    check_lit("rd_after_half", last_rd, 64'hBEEF3344AB667788);

    // Error responses: out of range, misaligned, oversized; back-to-back via ERR2.
    resp_cnt = 0;
    issue(1'b1, 2'b10, 1'b1, 64'h800, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    idle(3);
    check_lit("err_resp_cycles", 64'(resp_cnt), 64'd2);
    issue(1'b1, 2'b10, 1'b1, 64'h12, 3'd2, 64'hFFFFFFFFFFFFFFFF);
    issue(1'b1, 2'b10, 1'b1, 64'h10, 3'd4, 64'hFFFFFFFFFFFFFFFF);
    issue(1'b1, 2'b10, 1'b0, 64'h7F8, 3'd3, 64'd0);
    issue(1'b1, 2'b10, 1'b0, 64'h10, 3'd3, 64'd0);
    idle(2);
    check_lit("rd_after_errors", last_rd, 64'hBEEF3344AB667788);

    // Non-transfers: IDLE, BUSY, deselected NONSEQ.
    low_cnt = 0;
    issue(1'b1, 2'b00, 1'b1, 64'h10, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    issue(1'b1, 2'b01, 1'b1, 64'h10, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    issue(1'b0, 2'b10, 1'b1, 64'h10, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    issue(1'b1, 2'b10, 1'b0, 64'h10, 3'd3, 64'd0);
    idle(2);
    check_lit("no_wait_nontransfer", 64'(low_cnt), 64'd0);
    check_lit("rd_after_idle_busy", last_rd, 64'hBEEF3344AB667788);

    // Two wait states: single read, then back-to-back reads.
    dsel = 1;
    zero_words();
    issue(1'b1, 2'b10, 1'b1, 64'h10, 3'd3, 64'h0123456789ABCDEF);
    idle(2);
    low_cnt = 0;
    issue(1'b1, 2'b10, 1'b0, 64'h10, 3'd3, 64'd0);
    idle(4);
    check_lit("ws2_single_low", 64'(low_cnt), 64'd2);
    check_lit("ws2_rd", last_rd, 64'h0123456789ABCDEF);
    low_cnt = 0;
    issue(1'b1, 2'b10, 1'b0, 64'h10, 3'd3, 64'd0);
    issue(1'b1, 2'b11, 1'b0, 64'h7F8, 3'd3, 64'd0);
    idle(4);
    check_lit("ws2_b2b_low", 64'(low_cnt), 64'd4);
    check_lit("ws2_b2b_rd", last_rd, 64'd0);

    // Three wait states: reset during the second wait aborts the write.
    dsel = 2;
    zero_words();
    idle(1);
    issue(1'b1, 2'b10, 1'b1, 64'h20, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expq.delete();
    #1;
    check_lit("abort_hreadyout", {63'd0, hready_bus}, 64'd1);
    check_lit("abort_hresp", {63'd0, hresp_bus}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b1, 2'b10, 1'b0, 64'h20, 3'd3, 64'd0);
    idle(5);
    check_lit("abort_no_write", last_rd, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
